// File: rtl/posit_pkg.sv
// Shared posit types used across the posit datapath blocks.
// status_t packs the IEEE-style exception flags with NV in the MSB and NX in the LSB.
package posit_pkg;

   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } status_t;

   localparam status_t STATUS_NONE = '0;

endpackage

// File: rtl/posit_result_collector.sv
// Output queue behind posit_top: buffers result/status/tag in strict FIFO order
// and accumulates sticky exception flags of every accepted result.
module posit_result_collector
   import posit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   input  logic [WIDTH-1:0]         result_i,
   input  status_t                  status_i,
   input  logic                     tag_i,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [WIDTH-1:0]         result_o,
   output status_t                  status_o,
   output logic                     tag_o,
   input  logic                     flush_i,
   input  logic                     clear_flags_i,
   output status_t                  fflags_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     busy_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef struct packed {
      logic [WIDTH-1:0] result;
      status_t          status;
      logic             tag;
   } entry_t;

   entry_t          mem [DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count, count_nxt;
   logic            push, pop;
   entry_t          head;

   always_comb begin
      push      = in_valid_i && in_ready_o && !flush_i;
      pop       = out_valid_o && out_ready_i && !flush_i;
      count_nxt = count;
      if (flush_i)
         count_nxt = '0;
      else if (push && !pop)
         count_nxt = count + 1'b1;
      else if (pop && !push)
         count_nxt = count - 1'b1;
   end

   // Ready is registered from next-state count so a pop never combinationally frees a slot.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         in_ready_o <= 1'b0;
         fflags_o   <= STATUS_NONE;
      end else begin
         count      <= count_nxt;
         in_ready_o <= (count_nxt < DEPTH_C);
         if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
         end
         if (clear_flags_i)
            fflags_o <= push ? status_i : STATUS_NONE;
         else if (push)
            fflags_o <= status_t'(fflags_o | status_i);
      end
   end

   // Payload storage needs no reset: head outputs are masked while empty.
   always_ff @(posedge clk_i) begin
      if (push)
         mem[wr_ptr] <= '{result: result_i, status: status_i, tag: tag_i};
   end

   always_comb begin
      out_valid_o = (count != '0);
      busy_o      = out_valid_o;
      count_o     = count;
      head        = out_valid_o ? mem[rd_ptr] : '0;
      result_o    = head.result;
      status_o    = head.status;
      tag_o       = head.tag;
   end

endmodule

// File: doc/posit_result_collector.md
POSIT_RESULT_COLLECTOR -- requirements
Module: posit_result_collector

Interface
REQ-001 Parameter WIDTH, default 32, posit result width in bits.
REQ-002 Parameter DEPTH, default 4, queue entries; SHALL be a power of two, at least 2.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous and active-high.
REQ-005 in_valid_i  input  1  result from posit_top is valid (connects to posit_top out_valid_o).
REQ-006 in_ready_o  output  1  collector accepts a result (connects to posit_top out_ready_i).
REQ-007 result_i  input  WIDTH  posit result word.
REQ-008 status_i  input  posit_pkg::status_t  exception flags of the result: NV, DZ, OF, UF, NX, 5 bits.
REQ-009 tag_i  input  1  operation tag.
REQ-010 out_valid_o  output  1  head entry available to consumer.
REQ-011 out_ready_i  input  1  consumer takes head entry.
REQ-012 result_o  output  WIDTH  head entry result.
REQ-013 status_o  output  posit_pkg::status_t  head entry status.
REQ-014 tag_o  output  1  head entry tag.
REQ-015 flush_i  input  1  discard all queued entries.
REQ-016 clear_flags_i  input  1  clear sticky flags.
REQ-017 fflags_o  output  posit_pkg::status_t  sticky OR of the status of every accepted entry since the last clear.
REQ-018 count_o  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-019 busy_o  output  1  high when count_o is non-zero.

Function
REQ-020 Push SHALL occur on a rising edge with in_valid_i and in_ready_o both high and flush_i low.
REQ-021 Pop SHALL occur on a rising edge with out_valid_o and out_ready_i both high and flush_i low.
REQ-022 in_ready_o SHALL be a registered signal equal to (count < DEPTH), with no combinational path from out_ready_i.
REQ-023 Ordering SHALL be strict FIFO; result, status and tag of an entry stay together.
REQ-024 out_valid_o SHALL equal (count != 0); head outputs SHALL be driven from storage only, never bypassed from the inputs.
REQ-025 Latency: an entry pushed at edge N SHALL be visible at the outputs after edge N when the queue was empty.
REQ-026 Head outputs SHALL remain stable while out_valid_o is high and out_ready_i is low.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH; count SHALL change by +1 on push only, -1 on pop only, and 0 on simultaneous push and pop.
REQ-028 When full, in_ready_o SHALL be low, so a same-cycle pop frees the slot only from the next cycle.
REQ-029 When empty, a pop SHALL be impossible; a push SHALL make out_valid_o high on the next cycle.
REQ-030 flush_i SHALL zero the count and both pointers on the next edge and SHALL drop any same-cycle push or pop.
REQ-031 A dropped push SHALL not update fflags_o.
REQ-032 fflags_o SHALL be updated on each accepted push with fflags_o OR status_i.
REQ-033 clear_flags_i with a simultaneous push SHALL load fflags_o with that push's status_i only.
REQ-034 clear_flags_i with no push SHALL load fflags_o with zero.
REQ-035 When out_valid_o is low, result_o, status_o and tag_o SHALL be zero.

Reset
REQ-036 While rst_i is high, the following SHALL be zero: in_ready_o, out_valid_o, result_o, status_o, tag_o, fflags_o, count_o, busy_o and both pointers.
REQ-037 in_ready_o SHALL rise on the first rising edge after rst_i falls.
REQ-038 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.

Structure
REQ-039 status_t SHALL come from the shared posit_pkg; the collector SHALL define no local copy.
REQ-040 No sub-module is required; storage SHALL be an inline register array of DEPTH entries.

Verification
REQ-041 Reset, then push result 0x40000000 (1.0), status 5'b00001, tag 1, with out_ready_i low -> next cycle out_valid_o=1, result_o=0x40000000, tag_o=1, fflags_o=5'b00001, count_o=1.
REQ-042 Push 4 entries 0x40000000, 0x48000000, 0x50000000, 0x38000000 with out_ready_i low -> in_ready_o=0 after the 4th; 5th offered value is held off; draining yields the same order.
REQ-043 Full queue, in_valid_i and out_ready_i both high for 6 cycles -> pops on all 6 cycles; pushes only on cycles where in_ready_o was high; count_o never exceeds 4.
REQ-044 3 entries queued, flush_i high with in_valid_i high and status 5'b10000 -> count_o=0, out_valid_o=0; fflags_o does not gain NV.
REQ-045 fflags_o=5'b00011, clear_flags_i high with push of status 5'b00100 -> fflags_o=5'b00100.
REQ-046 rst_i pulsed asynchronously between edges with 2 entries queued -> outputs zero immediately; in_ready_o=1 one edge after release.
